// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between NUM_REQ byte sources.
// Requesters hand over bytes on a valid/ready handshake. A round-robin arbiter
// with packet locking chooses the source, and the bytes queue in a
// first-word-fall-through FIFO that feeds the transmitter's
// tx_data/tx_empty_status/tx_rd interface.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,    // number of requesters (2..8)
    parameter int DEPTH        = 8,    // FIFO entries, power of 2
    parameter int LOCK_TIMEOUT = 255   // idle cycles before a lock is dropped (1..255)
) (
    input  logic                        pclk,
    input  logic                        preset,
    input  logic                        enable,
    input  logic                        flush,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [8*NUM_REQ-1:0]        req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [7:0]                  tx_data,
    output logic                        tx_empty_status,
    input  logic                        tx_rd,
    output logic [$clog2(DEPTH):0]      fifo_level,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        lock_active,
    output logic                        lock_abort
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int GW = $clog2(NUM_REQ);

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;

    // Arbiter state
    state_t        r_state;
    logic [GW-1:0] r_grant_id;
    logic [GW-1:0] r_last_grant;
    logic [7:0]    r_timer;
    logic          r_lock_abort;

    // Next-state values for the arbiter registers
    state_t        w_state_nxt;
    logic [GW-1:0] w_grant_id_nxt;
    logic [GW-1:0] w_last_grant_nxt;
    logic [7:0]    w_timer_nxt;
    logic          w_lock_abort_nxt;

    // Combinational datapath signals
    logic          w_full;
    logic          w_empty;
    logic          w_can_push;
    logic          w_sel_found;
    logic [GW-1:0] w_sel_id;
    logic [GW-1:0] w_cand;
    logic          w_xfer;
    logic          w_xfer_last;
    logic [7:0]    w_xfer_data;
    logic          w_pop;

    // Fullness is taken from the registered level, so a same-cycle pop
    // never opens a slot for a push.
    assign w_full     = (r_level == LW'(DEPTH));
    assign w_empty    = (r_level == '0);
    // Reset also blocks ready, because req_ready is combinational from the inputs.
    assign w_can_push = enable & ~flush & ~preset & ~w_full;
    assign w_pop      = tx_rd & ~w_empty & ~flush;

    // Choose the candidate requester: the lock owner, or a round-robin search
    // that starts one past the last grant.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
        w_sel_found = 1'b0;
        w_sel_id    = '0;
        w_cand      = '0;
        if (r_state == ST_LOCK) begin
            w_sel_found = req_valid[r_grant_id];
            w_sel_id    = r_grant_id;
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                w_cand = GW'((int'(r_last_grant) + k) % NUM_REQ);
                if (!w_sel_found && req_valid[w_cand]) begin
                    w_sel_found = 1'b1;
                    w_sel_id    = w_cand;
                end
            end
        end
    end

    // Accept at most one byte per cycle; ready is already qualified by valid.
    assign req_ready   = (w_can_push && w_sel_found) ? (NUM_REQ'(1) << w_sel_id) : '0;
    assign w_xfer      = |req_ready;
    assign w_xfer_last = req_last[w_sel_id];
    assign w_xfer_data = req_data[{w_sel_id, 3'b000} +: 8];

    // FIFO payload write; the storage has no reset because level gates every read.
    always_ff @(posedge pclk) begin
        // NOTE: the memory array is deliberately left out of reset; contents are never observed while level is 0.
        if (w_xfer) begin
            r_mem[r_wr_ptr] <= w_xfer_data;
        end
    end

    // FIFO pointers and occupancy. Flush clears them and blocks push and pop.
    always_ff @(posedge pclk or posedge preset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (preset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_xfer) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_xfer, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Arbiter next state: grant tracking, packet lock entry and exit, and the idle timeout.
    always_comb begin
        w_state_nxt      = r_state;
        w_grant_id_nxt   = r_grant_id;
        w_last_grant_nxt = r_last_grant;
        w_timer_nxt      = r_timer;
        w_lock_abort_nxt = 1'b0;
        if (flush) begin
            w_state_nxt      = ST_ARB;
            w_timer_nxt      = '0;
            w_last_grant_nxt = GW'(NUM_REQ - 1);
        end else begin
            case (r_state)
                ST_ARB: begin
                    if (w_xfer) begin
                        w_grant_id_nxt   = w_sel_id;
                        w_last_grant_nxt = w_sel_id;
                        w_timer_nxt      = '0;
                        if (!w_xfer_last) begin
                            w_state_nxt = ST_LOCK;
                        end
                    end
                end
                ST_LOCK: begin
                    if (w_xfer) begin
                        w_grant_id_nxt   = w_sel_id;
                        w_last_grant_nxt = w_sel_id;
                        w_timer_nxt      = '0;
                        if (w_xfer_last) begin
                            w_state_nxt = ST_ARB;
                        end
                    end else if (enable) begin
                        // This idle cycle brings the count to LOCK_TIMEOUT, so release the lock now.
                        if (r_timer == 8'(LOCK_TIMEOUT - 1)) begin
                            w_state_nxt      = ST_ARB;
                            w_timer_nxt      = '0;
                            w_lock_abort_nxt = 1'b1;
                        end else begin
                            w_timer_nxt = r_timer + 8'd1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_ARB;
                end
            endcase
        end
    end

    // Arbiter state register.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state      <= ST_ARB;
            r_grant_id   <= '0;
            r_last_grant <= GW'(NUM_REQ - 1);
            r_timer      <= '0;
            r_lock_abort <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant_id   <= w_grant_id_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_timer      <= w_timer_nxt;
            r_lock_abort <= w_lock_abort_nxt;
        end
    end

    assign tx_data         = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign tx_empty_status = w_empty;
    assign fifo_level      = r_level;
    assign grant_id        = r_grant_id;
    assign lock_active     = (r_state == ST_LOCK);
    assign lock_abort      = r_lock_abort;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter (NUM_REQ=4, DEPTH=8, LOCK_TIMEOUT=4).
// A vector table covers round-robin fill, full back-pressure, drain and packet
// locking. Hand-written sequences cover lock timeout, flush and mid-packet reset.
module tb_uart_tx_arbiter;

    logic        pclk;
    logic        preset;
    logic        enable;
    logic        flush;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_empty_status;
    logic        tx_rd;
    logic [3:0]  fifo_level;
    logic [1:0]  grant_id;
    logic        lock_active;
    logic        lock_abort;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        en;
        logic        rd;
        logic [3:0]  vld;
        logic [3:0]  lst;
        logic [31:0] dat;
        logic [3:0]  rdy;   // expected req_ready before the edge
        logic [3:0]  lvl;   // expected fifo_level after the edge
        logic [7:0]  head;  // expected tx_data after the edge
        logic        lock;  // expected lock_active after the edge
        logic [1:0]  gid;   // expected grant_id after the edge
    } vec_t;

    vec_t vecs[$];

    uart_tx_arbiter #(
        .NUM_REQ     (4),
        .DEPTH       (8),
        .LOCK_TIMEOUT(4)
    ) dut (
        .pclk           (pclk),
        .preset         (preset),
        .enable         (enable),
        .flush          (flush),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_last       (req_last),
        .req_ready      (req_ready),
        .tx_data        (tx_data),
        .tx_empty_status(tx_empty_status),
        .tx_rd          (tx_rd),
        .fifo_level     (fifo_level),
        .grant_id       (grant_id),
        .lock_active    (lock_active),
        .lock_abort     (lock_abort)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge pclk);
        #1;
    endtask

    function automatic void add(input logic en, input logic rd, input logic [3:0] vld,
                                input logic [3:0] lst, input logic [31:0] dat,
                                input logic [3:0] rdy, input logic [3:0] lvl,
                                input logic [7:0] head, input logic lock,
                                input logic [1:0] gid);
        vec_t v;
        v.en = en; v.rd = rd; v.vld = vld; v.lst = lst; v.dat = dat;
        v.rdy = rdy; v.lvl = lvl; v.head = head; v.lock = lock; v.gid = gid;
        vecs.push_back(v);
    endfunction

    initial begin
        preset    = 1'b1;
        enable    = 1'b0;
        flush     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_rd     = 1'b0;

        //   en   rd   vld      lst      data          rdy      lvl  head   lk gid
        // Round-robin fill from requester 0 until full
        add(1'b1, 1'b0, 4'hF, 4'hF, 32'hA3A2A1A0, 4'b0001, 4'd1, 8'hA0, 1'b0, 2'd0);
        add(1'b1, 1'b0, 4'hF, 4'hF, 32'hA3A2A1A0, 4'b0010, 4'd2, 8'hA0, 1'b0, 2'd1);
        add(1'b1, 1'b0, 4'hF, 4'hF, 32'hA3A2A1A0, 4'b0100, 4'd3, 8'hA0, 1'b0, 2'd2);
        add(1'b1, 1'b0, 4'hF, 4'hF, 32'hA3A2A1A0, 4'b1000, 4'd4, 8'hA0, 1'b0, 2'd3);
        add(1'b1, 1'b0, 4'hF, 4'hF, 32'hA3A2A1A0, 4'b0001, 4'd5, 8'hA0, 1'b0, 2'd0);
        add(1'b1, 1'b0, 4'hF, 4'hF, 32'hA3A2A1A0, 4'b0010, 4'd6, 8'hA0, 1'b0, 2'd1);
        add(1'b1, 1'b0, 4'hF, 4'hF, 32'hA3A2A1A0, 4'b0100, 4'd7, 8'hA0, 1'b0, 2'd2);
        add(1'b1, 1'b0, 4'hF, 4'hF, 32'hA3A2A1A0, 4'b1000, 4'd8, 8'hA0, 1'b0, 2'd3);
        // Full: no ready, even with a same-cycle pop
        add(1'b1, 1'b0, 4'hF, 4'hF, 32'hA3A2A1A0, 4'b0000, 4'd8, 8'hA0, 1'b0, 2'd3);
        add(1'b1, 1'b1, 4'hF, 4'hF, 32'hA3A2A1A0, 4'b0000, 4'd7, 8'hA1, 1'b0, 2'd3);
        // Push and pop in the same cycle: level unchanged
        add(1'b1, 1'b1, 4'hF, 4'hF, 32'hA3A2A1A0, 4'b0001, 4'd7, 8'hA2, 1'b0, 2'd0);
        // Disabled: no ready, the FIFO still drains
        add(1'b0, 1'b1, 4'hF, 4'hF, 32'hA3A2A1A0, 4'b0000, 4'd6, 8'hA3, 1'b0, 2'd0);
        add(1'b1, 1'b1, 4'h0, 4'h0, 32'hA3A2A1A0, 4'b0000, 4'd5, 8'hA0, 1'b0, 2'd0);
        add(1'b1, 1'b1, 4'h0, 4'h0, 32'hA3A2A1A0, 4'b0000, 4'd4, 8'hA1, 1'b0, 2'd0);
        add(1'b1, 1'b1, 4'h0, 4'h0, 32'hA3A2A1A0, 4'b0000, 4'd3, 8'hA2, 1'b0, 2'd0);
        add(1'b1, 1'b1, 4'h0, 4'h0, 32'hA3A2A1A0, 4'b0000, 4'd2, 8'hA3, 1'b0, 2'd0);
        add(1'b1, 1'b1, 4'h0, 4'h0, 32'hA3A2A1A0, 4'b0000, 4'd1, 8'hA0, 1'b0, 2'd0);
        add(1'b1, 1'b1, 4'h0, 4'h0, 32'hA3A2A1A0, 4'b0000, 4'd0, 8'h00, 1'b0, 2'd0);
        // tx_rd while empty is ignored
        add(1'b1, 1'b1, 4'h0, 4'h0, 32'hA3A2A1A0, 4'b0000, 4'd0, 8'h00, 1'b0, 2'd0);
        // Requester 1 sends a 3-byte packet while requester 0 keeps asking
        add(1'b1, 1'b0, 4'b0011, 4'b0001, 32'h00001155, 4'b0010, 4'd1, 8'h11, 1'b1, 2'd1);
        add(1'b1, 1'b0, 4'b0011, 4'b0001, 32'h00002255, 4'b0010, 4'd2, 8'h11, 1'b1, 2'd1);
        add(1'b1, 1'b0, 4'b0011, 4'b0011, 32'h00003355, 4'b0010, 4'd3, 8'h11, 1'b0, 2'd1);
        add(1'b1, 1'b0, 4'b0001, 4'b0001, 32'h00003355, 4'b0001, 4'd4, 8'h11, 1'b0, 2'd0);
        // Drain: the packet bytes come out contiguously
        add(1'b1, 1'b1, 4'h0, 4'h0, 32'h0, 4'b0000, 4'd3, 8'h22, 1'b0, 2'd0);
        add(1'b1, 1'b1, 4'h0, 4'h0, 32'h0, 4'b0000, 4'd2, 8'h33, 1'b0, 2'd0);
        add(1'b1, 1'b1, 4'h0, 4'h0, 32'h0, 4'b0000, 4'd1, 8'h55, 1'b0, 2'd0);
        add(1'b1, 1'b1, 4'h0, 4'h0, 32'h0, 4'b0000, 4'd0, 8'h00, 1'b0, 2'd0);

        // Reset state
        cyc();
        cyc();
        check("rst ready", req_ready, 4'b0000);
        check("rst tx_data", tx_data, 8'h00);
        check("rst empty", tx_empty_status, 1'b1);
        check("rst level", fifo_level, 4'd0);
        check("rst grant_id", grant_id, 2'd0);
        check("rst lock", lock_active, 1'b0);
        check("rst abort", lock_abort, 1'b0);
        preset = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            enable    = vecs[i].en;
            tx_rd     = vecs[i].rd;
            req_valid = vecs[i].vld;
            req_last  = vecs[i].lst;
            req_data  = vecs[i].dat;
            #1;
            check($sformatf("v%0d ready", i), req_ready, vecs[i].rdy);
            cyc();
            check($sformatf("v%0d level", i), fifo_level, vecs[i].lvl);
            check($sformatf("v%0d empty", i), tx_empty_status, (vecs[i].lvl == 4'd0));
            check($sformatf("v%0d head", i), tx_data, vecs[i].head);
            check($sformatf("v%0d lock", i), lock_active, vecs[i].lock);
            check($sformatf("v%0d grant", i), grant_id, vecs[i].gid);
        end

        // Lock timeout: requester 2 locks, then goes idle
        enable    = 1'b1;
        tx_rd     = 1'b0;
        req_data  = 32'hD377B1C0;
        req_valid = 4'b0100;
        req_last  = 4'b0000;
        #1;
        check("to lock ready", req_ready, 4'b0100);
        cyc();
        check("to lock active", lock_active, 1'b1);
        check("to lock gid", grant_id, 2'd2);
        req_valid = 4'b1001;
        req_last  = 4'b1001;
        for (int n = 1; n <= 3; n++) begin
            #1;
            check($sformatf("to idle%0d ready", n), req_ready, 4'b0000);
            cyc();
            check($sformatf("to idle%0d lock", n), lock_active, 1'b1);
            check($sformatf("to idle%0d abort", n), lock_abort, 1'b0);
        end
        #1;
        check("to idle4 ready", req_ready, 4'b0000);
        cyc();
        check("to release lock", lock_active, 1'b0);
        check("to release abort", lock_abort, 1'b1);
        check("to kept level", fifo_level, 4'd1);
        check("to kept head", tx_data, 8'h77);
        #1;
        check("to next ready", req_ready, 4'b1000);
        cyc();
        check("to abort one cycle", lock_abort, 1'b0);
        check("to next gid", grant_id, 2'd3);
        check("to next level", fifo_level, 4'd2);
        #1;
        check("to wrap ready", req_ready, 4'b0001);
        cyc();
        check("to wrap level", fifo_level, 4'd3);

        // Flush with level 5 and a lock held
        req_valid = 4'b0010;
        req_last  = 4'b0000;
        #1;
        check("fl lock ready", req_ready, 4'b0010);
        cyc();
        check("fl lock active", lock_active, 1'b1);
        cyc();
        check("fl pre level", fifo_level, 4'd5);
        flush     = 1'b1;
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        #1;
        check("fl ready", req_ready, 4'b0000);
        cyc();
        flush = 1'b0;
        check("fl level", fifo_level, 4'd0);
        check("fl empty", tx_empty_status, 1'b1);
        check("fl lock", lock_active, 1'b0);
        check("fl abort", lock_abort, 1'b0);
        check("fl head", tx_data, 8'h00);
        #1;
        check("fl next ready", req_ready, 4'b0001);
        cyc();
        check("fl next gid", grant_id, 2'd0);
        check("fl next head", tx_data, 8'hC0);

        // Reset mid-packet with level 3
        req_valid = 4'b0010;
        req_last  = 4'b0000;
        cyc();
        cyc();
        check("mr pre level", fifo_level, 4'd3);
        check("mr pre lock", lock_active, 1'b1);
        check("mr pre gid", grant_id, 2'd1);
        #2;
        preset = 1'b1;
        #1;
        check("mr ready", req_ready, 4'b0000);
        check("mr tx_data", tx_data, 8'h00);
        check("mr empty", tx_empty_status, 1'b1);
        check("mr level", fifo_level, 4'd0);
        check("mr gid", grant_id, 2'd0);
        check("mr lock", lock_active, 1'b0);
        check("mr abort", lock_abort, 1'b0);
        cyc();
        preset    = 1'b0;
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        #1;
        check("mr restart ready", req_ready, 4'b0001);
        cyc();
        check("mr restart gid", grant_id, 2'd0);
        check("mr restart level", fifo_level, 4'd1);
        check("mr restart head", tx_data, 8'hC0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
